mlp_sample_sequencer: RTL
=========================

MLP_SAMPLE_SEQUENCER -- requirements
Module: mlp_sample_sequencer

Interface
REQ-001 Parameter NUM_A, default 8: number of input features per sample.
REQ-002 Parameter WIDTH_A, default 4: bits per feature, unsigned.
REQ-003 Parameter OUTWIDTH, default 2: class index width returned by the MLP.
REQ-004 Parameter SETTLE_CYCLES, default 4, legal range >=1: clocks allowed for the combinational MLP to settle.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 feat_valid  in  1  upstream feature word valid.
REQ-008 feat_data  in  WIDTH_A  feature value.
REQ-009 feat_ready  out  1  sequencer accepts a feature this cycle.
REQ-010 inp  out  NUM_A*WIDTH_A  packed features to MLP; feature i at bits [(i+1)*WIDTH_A-1 : i*WIDTH_A].
REQ-011 mlp_out  in  OUTWIDTH  combinational class result from MLP.
REQ-012 cls_valid  out  1  captured class available.
REQ-013 cls_data  out  OUTWIDTH  captured class.
REQ-014 cls_ready  in  1  downstream accepts class.
REQ-015 sample_count  out  16  number of classes delivered since reset.

Function
REQ-016 FSM states SHALL be LOAD, SETTLE, OUT; no other states.
REQ-017 feat_ready SHALL equal (state==LOAD) and not rst.
REQ-018 In LOAD, a feature SHALL be accepted when feat_valid && feat_ready; it is written into slot idx, idx increments by 1.
REQ-019 The first feature after reset or after a delivered class SHALL go into slot 0; arrival order = slot order.
REQ-020 Acceptance of the NUM_A-th feature SHALL move state to SETTLE, load settle counter with SETTLE_CYCLES-1, and reset idx to 0.
REQ-021 In SETTLE, each edge: counter==0 -> capture mlp_out into cls_data, set cls_valid, go OUT; else decrement counter.
REQ-022 cls_valid SHALL rise exactly SETTLE_CYCLES edges after the edge accepting the last feature.
REQ-023 inp SHALL not change from the last-feature edge until the class handshake completes; in LOAD only the written slot changes.
REQ-024 In OUT, cls_valid and cls_data SHALL hold stable until cls_valid && cls_ready; mlp_out changes SHALL not affect cls_data.
REQ-025 On class handshake: cls_valid clears, sample_count increments, state returns to LOAD; feat_ready asserts the following cycle.
REQ-026 sample_count SHALL wrap from 16'hFFFF to 16'h0000 without side effects.
REQ-027 Features SHALL not be accepted in SETTLE or OUT; no overlap between samples.
REQ-028 Partial samples persist indefinitely in LOAD while feat_valid is low; no timeout.

Reset
REQ-029 rst assertion SHALL immediately force state LOAD, idx 0, settle counter 0, inp all zeros, cls_valid 0, cls_data 0, sample_count 0, feat_ready 0.
REQ-030 Reset mid-LOAD, mid-SETTLE or mid-OUT SHALL discard the sample in progress; no class is emitted for it.
REQ-031 After rst deasserts, the first feature accepted SHALL land in slot 0.

Structure
REQ-032 Package mlp_seq_pkg SHALL hold the state enumeration and default parameter values (NUM_A, WIDTH_A, OUTWIDTH, SETTLE_CYCLES).
REQ-033 Sub-module settle_timer (load, count-down, done pulse) SHALL be the only sub-module; the MLP itself stays external.

Verification
REQ-034 Features 1,2,...,8 with feat_valid held high -> inp==32'h87654321 after 8th accept; feat_ready low next cycle.
REQ-035 mlp_out tied 2'd2, SETTLE_CYCLES=4 -> cls_valid rises exactly 4 edges after 8th accept, cls_data==2.
REQ-036 cls_ready low 10 cycles while mlp_out toggles 0->3 -> cls_data, inp stable, feat_ready 0; handshake -> sample_count 0->1.
REQ-037 rst pulsed during SETTLE after loading 8'd features -> inp==0, cls_valid never rises, next feature lands in slot 0.
REQ-038 Gapped feat_valid (one feature every 3 cycles) -> identical inp and timing relative to 8th accept as back-to-back case.
REQ-039 Force sample_count to 16'hFFFF via 65535 deliveries (or backdoor) -> next handshake yields 16'h0000.

Source files
------------

// File: rtl/mlp_seq_pkg.sv
// Shared types and default parameters for the MLP sample sequencer.
// Holds the FSM state encoding plus a width helper used by the top and its timer.
package mlp_seq_pkg;

    localparam int unsigned DEF_NUM_A         = 8;
    localparam int unsigned DEF_WIDTH_A       = 4;
    localparam int unsigned DEF_OUTWIDTH      = 2;
    localparam int unsigned DEF_SETTLE_CYCLES = 4;
    localparam int unsigned COUNT_W           = 16;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        OUT    = 2'd2
    } seq_state_e;

    // Counter width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Down-counter giving the external MLP a fixed number of clocks to settle.
// Loaded with CYCLES-1; done_c is high while running with the count at zero.
module settle_timer
    import mlp_seq_pkg::*;
#(
    parameter int unsigned CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic done_c
);

    localparam int unsigned CNT_W = clog2_min1(CYCLES);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= CNT_W'(CYCLES - 1);
        end else if (run && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign done_c = run && (cnt_q == '0);

endmodule

// File: rtl/mlp_sample_sequencer.sv
// Collects NUM_A features into a packed vector for an external combinational MLP,
// waits for it to settle, then holds the captured class until downstream takes it.
module mlp_sample_sequencer
    import mlp_seq_pkg::*;
#(
    parameter int unsigned NUM_A         = DEF_NUM_A,
    parameter int unsigned WIDTH_A       = DEF_WIDTH_A,
    parameter int unsigned OUTWIDTH      = DEF_OUTWIDTH,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       feat_valid,
    input  logic [WIDTH_A-1:0]         feat_data,
    output logic                       feat_ready,
    output logic [NUM_A*WIDTH_A-1:0]   inp,
    input  logic [OUTWIDTH-1:0]        mlp_out,
    output logic                       cls_valid,
    output logic [OUTWIDTH-1:0]        cls_data,
    input  logic                       cls_ready,
    output logic [COUNT_W-1:0]         sample_count
);

    localparam int unsigned IDX_W = clog2_min1(NUM_A);
    localparam int unsigned INP_W = NUM_A * WIDTH_A;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_A - 1);

    seq_state_e          state_q, state_n;
    logic [IDX_W-1:0]    idx_q, idx_n;
    logic [INP_W-1:0]    inp_q, inp_n;
    logic                cls_valid_q, cls_valid_n;
    logic [OUTWIDTH-1:0] cls_data_q, cls_data_n;
    logic [COUNT_W-1:0]  sample_count_q, sample_count_n;
    logic                accept_c;
    logic                timer_load_c;
    logic                timer_done_c;

    assign feat_ready   = (state_q == LOAD) && !rst;
    assign accept_c     = feat_valid && feat_ready;
    assign inp          = inp_q;
    assign cls_valid    = cls_valid_q;
    assign cls_data     = cls_data_q;
    assign sample_count = sample_count_q;

    settle_timer #(
        .CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load_c),
        .run    (state_q == SETTLE),
        .done_c (timer_done_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= LOAD;
            idx_q          <= '0;
            inp_q          <= '0;
            cls_valid_q    <= 1'b0;
            cls_data_q     <= '0;
            sample_count_q <= '0;
        end else begin
            state_q        <= state_n;
            idx_q          <= idx_n;
            inp_q          <= inp_n;
            cls_valid_q    <= cls_valid_n;
            cls_data_q     <= cls_data_n;
            sample_count_q <= sample_count_n;
        end
    end

    // Next-state and datapath; inp is frozen outside LOAD so the MLP sees a stable vector.
    always_comb begin
        state_n        = state_q;
        idx_n          = idx_q;
        inp_n          = inp_q;
        cls_valid_n    = cls_valid_q;
        cls_data_n     = cls_data_q;
        sample_count_n = sample_count_q;
        timer_load_c   = 1'b0;

        case (state_q)
            LOAD: begin
                if (accept_c) begin
                    for (int unsigned i = 0; i < NUM_A; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            inp_n[i*WIDTH_A +: WIDTH_A] = feat_data;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        idx_n        = '0;
                        timer_load_c = 1'b1;
                        state_n      = SETTLE;
                    end else begin
                        idx_n = idx_q + IDX_W'(1);
                    end
                end
            end
            SETTLE: begin
                if (timer_done_c) begin
                    cls_data_n  = mlp_out;
                    cls_valid_n = 1'b1;
                    state_n     = OUT;
                end
            end
            OUT: begin
                if (cls_ready) begin
                    cls_valid_n    = 1'b0;
                    sample_count_n = sample_count_q + COUNT_W'(1);
                    state_n        = LOAD;
                end
            end
            default: begin
                state_n = LOAD;
            end
        endcase
    end

endmodule
